// File: rtl/fifo_umbral.sv
// Eight-deep synchronous FIFO with programmable almost-full / almost-empty
// thresholds and one-cycle overflow/underflow error pulses.
module fifo_umbral #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [2:0]            umbral_alto,
  input  logic [2:0]            umbral_bajo,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  pop_ok, push_ok;

  // A push into a full FIFO is still taken when a pop frees a slot this edge;
  // a pop from an empty FIFO never falls through to the incoming word.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != DEPTH_C) || pop_ok);

  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == DEPTH_C);
  assign almost_full  = (umbral_alto != 3'd0) && (count >= (ADDR_WIDTH+1)'(umbral_alto));
  assign almost_empty = (count <= (ADDR_WIDTH+1)'(umbral_bajo));

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      valid_out <= pop_ok;
      error     <= (push && !push_ok) || (pop && !pop_ok);
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  // Storage is not cleared by reset; a push during reset is dropped.
  always_ff @(posedge clk) begin
    if (reset && push_ok) mem[wr_ptr] <= data_in;
  end
endmodule
